fork_n_avlstrm: RTL and testbench

- Parametrised N-way successor to the 2-way Avalon-ST packet fork.
- Two modes. Broadcast: each packet is replicated to a configurable subset of outputs. Steer: each packet goes to the single output selected by in_channel.
- Each output has its own packet FIFO, so one slow consumer does not stall the others until its FIFO fills.
- Sits between the parser and parallel downstream engines. Per-port packet and sop statistics are built in, plus a drop counter.

---
 rtl/fork_n_pkg.sv | 15 +
 rtl/fork_n_fifo.sv | 63 ++++++
 rtl/stats_cnt.sv | 24 ++
 rtl/fork_n_avlstrm.sv | 182 ++++++++++++++++++
 tb/tb_fork_n_avlstrm.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fork_n_pkg.sv
// Shared definitions for the N-way Avalon-ST packet fork: mode encodings,
// packet-tracking FSM states and the statistics counter width.
package fork_n_pkg;

    localparam int FORK_BCAST = 0;
    localparam int FORK_STEER = 1;

    localparam int STATS_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } fork_state_e;

endpackage

// File: rtl/fork_n_fifo.sv
// First-word-fall-through synchronous FIFO. A word written on one edge is
// visible on rd_data right after that edge. Full, empty and count are registered.
module fork_n_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 520
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push;
    logic             pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign push = wr_en & ~full;
    assign pop  = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;

endmodule

// File: rtl/stats_cnt.sv
// Free-running event counter. It increments by one on each cycle with inc high
// and wraps to zero after the all-ones value.
module stats_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (inc) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/fork_n_avlstrm.sv
// N-way Avalon-ST packet fork: broadcasts each packet to a mask of outputs or
// steers it by channel, buffering per output, with input/output/drop statistics.
module fork_n_avlstrm
    import fork_n_pkg::*;
#(
    parameter int N_OUT     = 4,
    parameter int DATA_W    = 512,
    parameter int EMPTY_W   = 6,
    parameter int CH_W      = 12,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 4,
    parameter int MODE      = FORK_BCAST
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_OUT-1:0]           cfg_out_en,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sop,
    input  logic                       in_eop,
    input  logic [EMPTY_W-1:0]         in_empty,
    input  logic [CH_W-1:0]            in_channel,
    output logic                       in_almost_full,
    output logic [N_OUT*DATA_W-1:0]    out_data,
    output logic [N_OUT-1:0]           out_valid,
    output logic [N_OUT-1:0]           out_sop,
    output logic [N_OUT-1:0]           out_eop,
    output logic [N_OUT*EMPTY_W-1:0]   out_empty,
    input  logic [N_OUT-1:0]           out_ready,
    input  logic [N_OUT-1:0]           out_almost_full,
    output logic [STATS_W-1:0]         stats_in_pkt,
    output logic [STATS_W-1:0]         stats_in_pkt_s,
    output logic [N_OUT*STATS_W-1:0]   stats_out_pkt,
    output logic [N_OUT*STATS_W-1:0]   stats_out_pkt_s,
    output logic [STATS_W-1:0]         stats_drop_pkt
);

    localparam int FW = DATA_W + EMPTY_W + 2;
    localparam int CW = $clog2(DEPTH) + 1;

    fork_state_e      state_reg, state_next;
    logic [N_OUT-1:0] pkt_mask_reg, pkt_mask_next;
    logic             rst_n_q;

    logic [N_OUT-1:0] tgt_steer;
    logic [N_OUT-1:0] tgt;
    logic [N_OUT-1:0] am;
    logic [N_OUT-1:0] full;
    logic [N_OUT-1:0] empty;
    logic [N_OUT-1:0] af_vec;
    logic [N_OUT-1:0] wr_en;
    logic [N_OUT-1:0] rd_en;
    logic             acc;
    logic             in_pkt;
    logic             pkt_active;
    logic [FW-1:0]    wr_word;

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_tgt
            assign tgt_steer[gi] = (in_channel == CH_W'(gi));
        end
    endgenerate

    assign tgt = (MODE == FORK_STEER) ? tgt_steer : cfg_out_en;

    assign in_pkt = (state_reg == IN_PKT);

    // Stray non-sop beats in IDLE get an empty mask: accepted, then discarded.
    always_comb begin
        am = '0;
        if (in_sop) begin
            am = tgt;
        end else if (in_pkt) begin
            am = pkt_mask_reg;
        end
    end

    assign in_ready   = rst_n & rst_n_q & (&(~full | ~am));
    assign acc        = in_valid & in_ready;
    assign pkt_active = in_sop | in_pkt;
    assign wr_en      = {N_OUT{acc}} & am;
    assign wr_word    = {in_sop, in_eop, in_empty, in_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            pkt_mask_reg <= '0;
            rst_n_q      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pkt_mask_reg <= pkt_mask_next;
            rst_n_q      <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pkt_mask_next = pkt_mask_reg;
        if (acc) begin
            if (in_sop) begin
                pkt_mask_next = tgt;
                state_next    = in_eop ? IDLE : IN_PKT;
            end else if (in_pkt && in_eop) begin
                state_next = IDLE;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
            logic [FW-1:0] rd_word;
            logic [CW-1:0] fifo_count;
            logic [CW-1:0] free_slots;

            fork_n_fifo #(
                .DEPTH (DEPTH),
                .WIDTH (FW)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .wr_en   (wr_en[gi]),
                .wr_data (wr_word),
                .rd_en   (rd_en[gi]),
                .rd_data (rd_word),
                .full    (full[gi]),
                .empty   (empty[gi]),
                .count   (fifo_count)
            );

            assign out_valid[gi] = rst_n & ~empty[gi];
            assign rd_en[gi]     = out_valid[gi] & out_ready[gi];

            assign out_data[gi*DATA_W +: DATA_W]    = rd_word[DATA_W-1:0];
            assign out_empty[gi*EMPTY_W +: EMPTY_W] = rd_word[DATA_W +: EMPTY_W];
            assign out_eop[gi]                      = rd_word[FW-2];
            assign out_sop[gi]                      = rd_word[FW-1];

            assign free_slots  = CW'(DEPTH) - fifo_count;
            assign af_vec[gi]  = (free_slots <= CW'(AF_MARGIN)) | out_almost_full[gi];

            stats_cnt #(.W(STATS_W)) u_out_pkt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (rd_en[gi] & out_eop[gi]),
                .cnt   (stats_out_pkt[gi*STATS_W +: STATS_W])
            );

            stats_cnt #(.W(STATS_W)) u_out_sop (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (rd_en[gi] & out_sop[gi]),
                .cnt   (stats_out_pkt_s[gi*STATS_W +: STATS_W])
            );
        end
    endgenerate

    assign in_almost_full = rst_n & rst_n_q & (|af_vec);

    stats_cnt #(.W(STATS_W)) u_in_pkt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (acc & in_eop & pkt_active),
        .cnt   (stats_in_pkt)
    );

    stats_cnt #(.W(STATS_W)) u_in_sop (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (acc & in_sop),
        .cnt   (stats_in_pkt_s)
    );

    // A packet whose target set is empty counts as dropped when its eop passes.
    stats_cnt #(.W(STATS_W)) u_drop (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (acc & in_eop & pkt_active & (am == '0)),
        .cnt   (stats_drop_pkt)
    );

endmodule

// File: tb/tb_fork_n_avlstrm.sv
// Directed bench for fork_n_avlstrm: a broadcast instance and a steer instance
// share one input bus; each scenario task checks its own expected values.
module tb_fork_n_avlstrm;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int EW = 6;
    localparam int CW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic [N-1:0]  cfg_out_en = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic [EW-1:0] in_empty = '0;
    logic [CW-1:0] in_channel = '0;
    logic [N-1:0]  out_ready = '1;
    logic [N-1:0]  out_almost_full = '0;

    logic            in_ready_b, in_af_b, in_ready_s, in_af_s;
    logic [N*DW-1:0] out_data_b, out_data_s;
    logic [N-1:0]    out_valid_b, out_sop_b, out_eop_b, out_valid_s, out_sop_s, out_eop_s;
    logic [N*EW-1:0] out_empty_b, out_empty_s;
    logic [31:0]     in_pkt_b, in_sop_b, drop_b, in_pkt_s, in_sop_s, drop_s;
    logic [N*32-1:0] out_pkt_b, out_sop_cnt_b, out_pkt_s, out_sop_cnt_s;

    fork_n_avlstrm #(.N_OUT(N), .DATA_W(DW), .EMPTY_W(EW), .CH_W(CW), .DEPTH(16),
                     .AF_MARGIN(4), .MODE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_out_en(cfg_out_en),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b), .in_sop(in_sop),
        .in_eop(in_eop), .in_empty(in_empty), .in_channel(in_channel),
        .in_almost_full(in_af_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_sop(out_sop_b), .out_eop(out_eop_b), .out_empty(out_empty_b),
        .out_ready(out_ready), .out_almost_full(out_almost_full),
        .stats_in_pkt(in_pkt_b), .stats_in_pkt_s(in_sop_b), .stats_out_pkt(out_pkt_b),
        .stats_out_pkt_s(out_sop_cnt_b), .stats_drop_pkt(drop_b)
    );

    fork_n_avlstrm #(.N_OUT(N), .DATA_W(DW), .EMPTY_W(EW), .CH_W(CW), .DEPTH(16),
                     .AF_MARGIN(4), .MODE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .cfg_out_en(cfg_out_en),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_s), .in_sop(in_sop),
        .in_eop(in_eop), .in_empty(in_empty), .in_channel(in_channel),
        .in_almost_full(in_af_s), .out_data(out_data_s), .out_valid(out_valid_s),
        .out_sop(out_sop_s), .out_eop(out_eop_s), .out_empty(out_empty_s),
        .out_ready(out_ready), .out_almost_full(out_almost_full),
        .stats_in_pkt(in_pkt_s), .stats_in_pkt_s(in_sop_s), .stats_out_pkt(out_pkt_s),
        .stats_out_pkt_s(out_sop_cnt_s), .stats_drop_pkt(drop_s)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int t0 = 0;
    logic use_s = 1'b0;
    logic rdy;
    assign rdy = use_s ? in_ready_s : in_ready_b;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitors: inputs only change just after posedge, so a handshake
    // seen at negedge is the pop that happens on the next posedge.
    logic [DW-1:0] cap_b [N][32];
    logic [DW-1:0] cap_s [N][32];
    int n_b [N];
    int n_s [N];
    int first_b [N];

    always @(negedge clk) begin
        for (int j = 0; j < N; j++) begin
            if (!rst_n) begin
                n_b[j] <= 0;
                n_s[j] <= 0;
                first_b[j] <= -1;
            end else begin
                if (out_valid_b[j] && out_ready[j]) begin
                    if (n_b[j] == 0) first_b[j] <= cyc;
                    if (n_b[j] < 32) cap_b[j][n_b[j]] <= out_data_b[j*DW +: DW];
                    n_b[j] <= n_b[j] + 1;
                end
                if (out_valid_s[j] && out_ready[j]) begin
                    if (n_s[j] < 32) cap_s[j][n_s[j]] <= out_data_s[j*DW +: DW];
                    n_s[j] <= n_s[j] + 1;
                end
            end
        end
    end

    task automatic idle();
        in_valid = 1'b0;
        in_sop = 1'b0;
        in_eop = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        out_ready = '1;
        out_almost_full = '0;
        cfg_out_en = '0;
        in_channel = '0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(1);
    endtask

    // Present one beat and hold it until accepted; t0 records the cycle of acceptance.
    task automatic send_beat(input logic sop, input logic eop, input logic [CW-1:0] ch,
                             input logic [DW-1:0] d);
        int n;
        in_valid = 1'b1;
        in_sop = sop;
        in_eop = eop;
        in_channel = ch;
        in_data = d;
        in_empty = eop ? 6'd3 : 6'd0;
        #1;
        n = 0;
        while (!rdy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) begin
            tests_run++; tests_failed++;
            $display("FAIL send_timeout data=%0h ready stayed 0 for %0d cycles", d, n);
        end
        t0 = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        out_almost_full = '1;
        wait_cycles(2);
        tests_run++;
        if ({in_ready_b, in_ready_s, in_af_b, in_af_s} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_in got=%b exp=0000", {in_ready_b, in_ready_s, in_af_b, in_af_s});
        end
        tests_run++;
        if ({out_valid_b, out_valid_s} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_out_valid got=%h exp=00", {out_valid_b, out_valid_s});
        end
        tests_run++;
        if ({in_pkt_b, drop_s, out_pkt_b} !== '0) begin
            tests_failed++;
            $display("FAIL reset_stats got=%h exp=0", {in_pkt_b, drop_s, out_pkt_b});
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if ({in_ready_b, in_af_b} !== 2'b00) begin
            tests_failed++;
            $display("FAIL release_cycle got=%b exp=00", {in_ready_b, in_af_b});
        end
        wait_cycles(1);
        tests_run++;
        if ({in_ready_b, in_af_b} !== 2'b11) begin
            tests_failed++;
            $display("FAIL after_release got=%b exp=11", {in_ready_b, in_af_b});
        end
        out_almost_full = '0;
        #1;
        tests_run++;
        if (in_af_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL af_idle got=%b exp=0", in_af_b);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_broadcast();
        int exp_n [N] = '{3, 3, 0, 3};
        int sop_cyc;
        do_reset();
        use_s = 1'b0;
        cfg_out_en = 4'b1011;
        send_beat(1'b1, 1'b0, 12'd0, 32'hA000_0000);
        sop_cyc = t0;
        send_beat(1'b0, 1'b0, 12'd0, 32'hA000_0001);
        send_beat(1'b0, 1'b1, 12'd0, 32'hA000_0002);
        idle();
        wait_cycles(5);
        for (int j = 0; j < N; j++) begin
            tests_run++;
            if (n_b[j] !== exp_n[j]) begin
                tests_failed++;
                $display("FAIL bcast_beats out%0d got=%0d exp=%0d", j, n_b[j], exp_n[j]);
            end
        end
        tests_run++;
        if (cap_b[3][2] !== 32'hA000_0002 || cap_b[1][0] !== 32'hA000_0000) begin
            tests_failed++;
            $display("FAIL bcast_data got=%h,%h exp=a0000002,a0000000", cap_b[3][2], cap_b[1][0]);
        end
        tests_run++;
        if (first_b[0] !== sop_cyc + 1) begin
            tests_failed++;
            $display("FAIL bcast_latency got=%0d exp=%0d", first_b[0], sop_cyc + 1);
        end
        tests_run++;
        if (in_pkt_b !== 32'd1 || in_sop_b !== 32'd1) begin
            tests_failed++;
            $display("FAIL bcast_in_stats got=%0d,%0d exp=1,1", in_pkt_b, in_sop_b);
        end
        tests_run++;
        if (out_pkt_b !== {32'd1, 32'd0, 32'd1, 32'd1} || out_sop_cnt_b !== {32'd1, 32'd0, 32'd1, 32'd1}) begin
            tests_failed++;
            $display("FAIL bcast_out_stats got=%h sop=%h exp=1/0/1/1", out_pkt_b, out_sop_cnt_b);
        end
        $display("[TB] test_broadcast done");
    endtask

    task automatic test_steer();
        int exp_n [N] = '{1, 0, 2, 0};
        do_reset();
        use_s = 1'b1;
        send_beat(1'b1, 1'b0, 12'd2, 32'hB000_0000);
        send_beat(1'b0, 1'b1, 12'd2, 32'hB000_0001);
        send_beat(1'b1, 1'b1, 12'd0, 32'hC000_0000);
        send_beat(1'b1, 1'b0, 12'd7, 32'hD000_0000);
        send_beat(1'b0, 1'b1, 12'd7, 32'hD000_0001);
        idle();
        wait_cycles(5);
        for (int j = 0; j < N; j++) begin
            tests_run++;
            if (n_s[j] !== exp_n[j]) begin
                tests_failed++;
                $display("FAIL steer_beats out%0d got=%0d exp=%0d", j, n_s[j], exp_n[j]);
            end
        end
        tests_run++;
        if (cap_s[2][1] !== 32'hB000_0001 || cap_s[0][0] !== 32'hC000_0000) begin
            tests_failed++;
            $display("FAIL steer_data got=%h,%h exp=b0000001,c0000000", cap_s[2][1], cap_s[0][0]);
        end
        tests_run++;
        if (drop_s !== 32'd1 || in_pkt_s !== 32'd3) begin
            tests_failed++;
            $display("FAIL steer_drop got drop=%0d in=%0d exp=1,3", drop_s, in_pkt_s);
        end
        tests_run++;
        if (out_pkt_s !== {32'd0, 32'd1, 32'd0, 32'd1}) begin
            tests_failed++;
            $display("FAIL steer_out_stats got=%h exp=0/1/0/1", out_pkt_s);
        end
        $display("[TB] test_steer done");
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        do_reset();
        use_s = 1'b1;
        out_ready = 4'b1101;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1;
            in_channel = 12'd1; in_data = 32'h300 + i; in_empty = 6'd3;
            #1;
            if (!rdy) break;
            @(posedge clk);
            #1;
            accepted++;
            tests_run++;
            if (in_af_s !== (accepted >= 12)) begin
                tests_failed++;
                $display("FAIL bp_af count=%0d got=%b exp=%b", accepted, in_af_s, accepted >= 12);
            end
        end
        tests_run++;
        if (accepted !== 16) begin
            tests_failed++;
            $display("FAIL bp_accepted got=%0d exp=16", accepted);
        end
        wait_cycles(3);
        tests_run++;
        if (in_ready_s !== 1'b0 || n_s[1] !== 0 || out_empty_s[EW +: EW] !== 6'd3) begin
            tests_failed++;
            $display("FAIL bp_stall ready=%b pops=%0d empty=%0d exp 0,0,3", in_ready_s, n_s[1], out_empty_s[EW +: EW]);
        end
        in_valid = 1'b0; in_channel = 12'd0;
        #1;
        tests_run++;
        if (in_ready_s !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_isolation ch0 ready got=%b exp=1", in_ready_s);
        end
        out_ready = '1;
        for (int i = accepted; i < 20; i++) send_beat(1'b1, 1'b1, 12'd1, 32'h300 + i);
        send_beat(1'b1, 1'b1, 12'd0, 32'hE000_0000);
        idle();
        wait_cycles(30);
        tests_run++;
        if (n_s[1] !== 20 || cap_s[1][16] !== 32'h310 || cap_s[1][19] !== 32'h313) begin
            tests_failed++;
            $display("FAIL bp_drain beats=%0d d16=%h d19=%h exp 20,310,313", n_s[1], cap_s[1][16], cap_s[1][19]);
        end
        tests_run++;
        if (n_s[0] !== 1 || cap_s[0][0] !== 32'hE000_0000 || in_af_s !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_ch0 beats=%0d data=%h af=%b exp 1,e0000000,0", n_s[0], cap_s[0][0], in_af_s);
        end
        out_almost_full = 4'b0100;
        #1;
        tests_run++;
        if (in_af_s !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_downstream_af got=%b exp=1", in_af_s);
        end
        out_almost_full = '0;
        $display("[TB] test_backpressure done");
    endtask

    task automatic test_mask_latch();
        int exp_n [N] = '{5, 2, 2, 2};
        do_reset();
        use_s = 1'b0;
        cfg_out_en = 4'b0001;
        send_beat(1'b1, 1'b0, 12'd0, 32'hF000_0000);
        cfg_out_en = 4'b1111;
        send_beat(1'b0, 1'b0, 12'd0, 32'hF000_0001);
        send_beat(1'b0, 1'b1, 12'd0, 32'hF000_0002);
        send_beat(1'b1, 1'b0, 12'd0, 32'h6000_0000);
        send_beat(1'b0, 1'b1, 12'd0, 32'h6000_0001);
        idle();
        wait_cycles(5);
        for (int j = 0; j < N; j++) begin
            tests_run++;
            if (n_b[j] !== exp_n[j]) begin
                tests_failed++;
                $display("FAIL latch_beats out%0d got=%0d exp=%0d", j, n_b[j], exp_n[j]);
            end
        end
        tests_run++;
        if (cap_b[0][2] !== 32'hF000_0002 || cap_b[1][0] !== 32'h6000_0000 || cap_b[3][1] !== 32'h6000_0001) begin
            tests_failed++;
            $display("FAIL latch_data got=%h,%h,%h", cap_b[0][2], cap_b[1][0], cap_b[3][1]);
        end
        $display("[TB] test_mask_latch done");
    endtask

    task automatic test_reset_midpkt();
        do_reset();
        use_s = 1'b0;
        cfg_out_en = 4'b1111;
        out_ready = '0;
        send_beat(1'b1, 1'b0, 12'd0, 32'h7000_0000);
        send_beat(1'b0, 1'b0, 12'd0, 32'h7000_0001);
        idle();
        tests_run++;
        if (out_valid_b !== 4'hF || out_sop_b !== 4'hF || out_eop_b !== 4'h0 || in_sop_b !== 32'd1) begin
            tests_failed++;
            $display("FAIL midpkt_before valid=%h sop=%h eop=%h sops=%0d", out_valid_b, out_sop_b, out_eop_b, in_sop_b);
        end
        rst_n = 1'b0;
        wait_cycles(1);
        rst_n = 1'b1;
        tests_run++;
        if (out_valid_b !== 4'h0 || in_ready_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL midpkt_flush valid=%h ready=%b exp 0,0", out_valid_b, in_ready_b);
        end
        tests_run++;
        if ({in_pkt_b, in_sop_b, out_pkt_b, out_sop_cnt_b, drop_b} !== '0) begin
            tests_failed++;
            $display("FAIL midpkt_stats in=%0d sop=%0d drop=%0d exp all zero", in_pkt_b, in_sop_b, drop_b);
        end
        out_ready = '1;
        wait_cycles(1);
        send_beat(1'b0, 1'b1, 12'd0, 32'h7000_0004);
        idle();
        wait_cycles(2);
        tests_run++;
        if (in_pkt_b !== 32'd0 || out_valid_b !== 4'h0) begin
            tests_failed++;
            $display("FAIL midpkt_stray in=%0d valid=%h exp 0,0", in_pkt_b, out_valid_b);
        end
        send_beat(1'b1, 1'b0, 12'd0, 32'h8000_0000);
        send_beat(1'b0, 1'b1, 12'd0, 32'h8000_0001);
        idle();
        wait_cycles(5);
        for (int j = 0; j < N; j++) begin
            tests_run++;
            if (n_b[j] !== 2 || cap_b[j][0] !== 32'h8000_0000) begin
                tests_failed++;
                $display("FAIL midpkt_next out%0d beats=%0d first=%h exp 2,80000000", j, n_b[j], cap_b[j][0]);
            end
        end
        tests_run++;
        if (in_pkt_b !== 32'd1 || drop_b !== 32'd0) begin
            tests_failed++;
            $display("FAIL midpkt_next_stats in=%0d drop=%0d exp 1,0", in_pkt_b, drop_b);
        end
        $display("[TB] test_reset_midpkt done");
    endtask

    task automatic test_wrap();
        do_reset();
        use_s = 1'b0;
        cfg_out_en = 4'b0001;
        force dut_b.u_in_pkt.cnt_reg = 32'hFFFF_FFFF;
        wait_cycles(1);
        release dut_b.u_in_pkt.cnt_reg;
        send_beat(1'b1, 1'b1, 12'd0, 32'h9000_0000);
        idle();
        wait_cycles(2);
        tests_run++;
        if (in_pkt_b !== 32'd0) begin
            tests_failed++;
            $display("FAIL wrap_in_pkt got=%h exp=0", in_pkt_b);
        end
        tests_run++;
        if (in_sop_b !== 32'd1 || out_pkt_b[31:0] !== 32'd1) begin
            tests_failed++;
            $display("FAIL wrap_other sop=%0d out0=%0d exp 1,1", in_sop_b, out_pkt_b[31:0]);
        end
        $display("[TB] test_wrap done");
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_steer();
        test_backpressure();
        test_mask_latch();
        test_reset_midpkt();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
